cmd_rank_arbiter: RTL and testbench
===================================

# cmd_rank_arbiter

- Channel-level CMD bus arbiter that picks which rank controller may issue the next command.
- Applies a round-robin policy with an optional same-rank hold window, so it can batch commands and cut rank switches.
- Sits directly upstream of the CMD turnaround timer: it drives `rankTransition` into the timer and consumes `CMDTurnaroundFree` back.
- Grants go out to the rank controllers as registered one-hot pulses.

## Interface
- `NUM_RANK`, default 4: number of ranks on the channel; must be a power of two, ≥2.
- `MAX_HOLD`, default 4: maximum consecutive grants to one rank while another rank is waiting; ≥1.
- `clk`  in  1  clock (single clock domain).
- `rst`  in  1  reset; asynchronous, active-low.
- `rankReq`  in  NUM_RANK  per-rank command-ready level; held until that rank sees its grant.
- `CMDTurnaroundFree`  in  1  CMD bus free of rank-to-rank turnaround. Drops in the same cycle `rankTransition` is high and stays low tRTRS cycles in total.
- `cmdGrant`  out  NUM_RANK  registered one-hot grant; single-cycle pulse per command.
- `grantRank`  out  $clog2(NUM_RANK)  index of the current rank; valid whenever `cmdGrant` is non-zero.
- `rankTransition`  out  1  registered single-cycle pulse requesting a turnaround window.

## Operation
- State: `curRank`, `curValid`, `holdCnt` (width $clog2(MAX_HOLD+1)), `nextRank`.
- FSM states:
  - ACTIVE: granting the current rank.
  - SWITCH: `rankTransition` high.
  - WAIT: turnaround in progress.
- Eligible set: `elig = rankReq & ~cmdGrant`. Masking the just-granted bit prevents a double grant, so a rank gets at most one grant every 2 cycles.
- ACTIVE, when `CMDTurnaroundFree`=1, first matching rule wins:
  1. `!curValid` and elig≠0: grant the round-robin winner with no transition. Set `curRank`, set `curValid`=1, set `holdCnt`=1.
  2. `elig[curRank]` and `holdCnt`<MAX_HOLD: grant `curRank`; `holdCnt`++.
  3. Another rank is eligible: `nextRank` = first eligible index searching `curRank`+1, +2, … modulo NUM_RANK (wraps). Go to SWITCH; `holdCnt`=0.
  4. Only `curRank` is eligible with hold expired: grant it; `holdCnt`=1.
  5. Otherwise: no grant.
- ACTIVE with `CMDTurnaroundFree`=0: no grant, no state change.
- SWITCH: `rankTransition`=1 for exactly this cycle. Set `curRank`=`nextRank`, then go to WAIT.
- WAIT, while `CMDTurnaroundFree`=0: stay in WAIT.
- WAIT, when `CMDTurnaroundFree`=1: if `elig[curRank]`, grant it and set `holdCnt`=1. Either way return to ACTIVE. A rank that dropped its request is not granted, and no further transition is issued.
- `rankReq` changes during SWITCH or WAIT do not re-target `nextRank`.
- Reset, asynchronous, including mid-operation: `cmdGrant`=0, `grantRank`=0, `rankTransition`=0, state ACTIVE, `curValid`=0, `curRank`=0, `holdCnt`=0. Outputs clear immediately, with no clock edge needed.

## Timing
- Same-rank grant: decision in cycle N, `cmdGrant` visible in N+1.
- Rank switch, tRTRS=2:
  - Decision in cycle 0.
  - `rankTransition` high in cycle 1; free=0.
  - WAIT in cycle 2; free=0.
  - Cycle 3: free=1, grant registered.
  - `cmdGrant` visible in cycle 4.
- General rule: switch-to-grant latency is tRTRS+2 cycles.
- `rankTransition` and `cmdGrant` are never high in the same cycle.
- `cmdGrant` is never asserted while `CMDTurnaroundFree` was 0 in the deciding cycle.

## Configuration
- Macro: `CMD_RANK_HOLD_EN`.
- Defined: hold window of MAX_HOLD consecutive grants, as described in Operation.
- Undefined: MAX_HOLD is treated as 1. Rule 2 never fires while another rank is eligible, giving pure round-robin with a rank switch on every contended grant.

## Test plan
- Reset, then `rankReq`=4'b0100 held → `cmdGrant`=4'b0100 one cycle after release, with no `rankTransition`. Grants then repeat every 2 cycles.
- `curRank`=0, with `rankReq`=4'b0011 constant, hold enabled, MAX_HOLD=4 → 4 grants to rank 0, then `rankTransition` pulse, then grant to rank 1 exactly 4 cycles after the decision.
- Same stimulus with `CMD_RANK_HOLD_EN` undefined → grants alternate 0/1, with a `rankTransition` before every grant.
- `curRank`=3, `rankReq`=4'b1111 → next switch targets rank 0 (wrap-around), then 1, 2, 3 in order.
- Rank 2 drops `rankReq` during WAIT → no grant, return to ACTIVE with `curRank`=2, no second `rankTransition`.
- Assert `rst` while in WAIT with `rankTransition` or `cmdGrant` pending → all outputs 0 immediately. The first post-reset grant has no transition.

Source files
------------

// File: rtl/cmd_rank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cmd_rank_arbiter
// Description : Channel CMD-bus arbiter. Round-robin between ranks with an
//               optional same-rank hold window. A change of rank produces a
//               rankTransition pulse for the turnaround timer. The next grant
//               is issued only once CMDTurnaroundFree comes back.
//               Build option: CMD_RANK_HOLD_EN enables the hold window of
//               MAX_HOLD grants. Without it the window is one grant, so every
//               contended grant switches rank.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_rank_arbiter #(
    parameter int NUM_RANK = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RANK-1:0]         rankReq,
    input  logic                        CMDTurnaroundFree,
    output logic [NUM_RANK-1:0]         cmdGrant,
    output logic [$clog2(NUM_RANK)-1:0] grantRank,
    output logic                        rankTransition
);

    localparam int c_RANK_W = $clog2(NUM_RANK);
    localparam int c_HOLD_W = $clog2(MAX_HOLD + 1);
`ifdef CMD_RANK_HOLD_EN
    localparam int c_HOLD_LIMIT = MAX_HOLD;
`else
    localparam int c_HOLD_LIMIT = 1;
`endif
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(c_HOLD_LIMIT);

    typedef enum logic [1:0] {
        S_ACTIVE = 2'd0,
        S_SWITCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_RANK_W-1:0]   r_curRank;
    logic [c_RANK_W-1:0]   r_nextRank;
    logic                  r_curValid;
    logic [c_HOLD_W-1:0]   r_holdCnt;

    logic [NUM_RANK-1:0]   w_elig;
    logic [NUM_RANK-1:0]   w_curMask;
    logic [NUM_RANK-1:0]   w_others;
    logic                  w_holdOpen;
    logic                  w_midHold;
    logic [c_RANK_W-1:0]   w_rrPick;
    logic [c_RANK_W-1:0]   w_nextPick;

    // First set bit of vec, searching upward from start and wrapping around.
    // NUM_RANK is a power of two, so the index addition wraps by itself.
    function automatic logic [c_RANK_W-1:0] firstFrom(
        input logic [NUM_RANK-1:0] vec,
        input logic [c_RANK_W-1:0] start
    );
        logic [c_RANK_W-1:0] idx;
        logic [c_RANK_W-1:0] pick;
        logic                found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < NUM_RANK; i++) begin
            idx = start + c_RANK_W'(i);
            if (!found && vec[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Eligibility and candidate selection for the current cycle.
    always_comb begin
        w_elig     = rankReq & ~cmdGrant;
        w_curMask  = NUM_RANK'(1) << r_curRank;
        w_others   = w_elig & ~w_curMask;
        w_holdOpen = (r_holdCnt < c_HOLD_MAX);
        // The current rank was granted in the previous cycle and is masked
        // only for one bubble cycle. It is still requesting and its window
        // is still open, so the arbiter must not switch away in this cycle.
        w_midHold  = r_curValid && cmdGrant[r_curRank] && rankReq[r_curRank]
                     && w_holdOpen;
        w_rrPick   = firstFrom(w_elig, r_curRank);
        w_nextPick = firstFrom(w_others, r_curRank + c_RANK_W'(1));
    end

    // Arbitration FSM with registered grant and transition outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_ACTIVE;
            r_curRank      <= '0;
            r_nextRank     <= '0;
            r_curValid     <= 1'b0;
            r_holdCnt      <= '0;
            cmdGrant       <= '0;
            grantRank      <= '0;
            rankTransition <= 1'b0;
        end else begin
            cmdGrant       <= '0;
            rankTransition <= 1'b0;
            case (r_state)
                S_ACTIVE: begin
                    if (CMDTurnaroundFree) begin
                        if (!r_curValid) begin
                            // No owner yet: take the first requester, with no turnaround.
                            if (w_elig != '0) begin
                                cmdGrant   <= NUM_RANK'(1) << w_rrPick;
                                grantRank  <= w_rrPick;
                                r_curRank  <= w_rrPick;
                                r_curValid <= 1'b1;
                                r_holdCnt  <= c_HOLD_W'(1);
                            end
                        end else if (w_elig[r_curRank] && w_holdOpen) begin
                            cmdGrant  <= w_curMask;
                            grantRank <= r_curRank;
                            r_holdCnt <= r_holdCnt + c_HOLD_W'(1);
                        end else if ((w_others != '0) && !w_midHold) begin
                            r_nextRank     <= w_nextPick;
                            r_holdCnt      <= '0;
                            rankTransition <= 1'b1;
                            r_state        <= S_SWITCH;
                        end else if (w_elig[r_curRank]) begin
                            // Window expired but nobody else wants the bus.
                            cmdGrant  <= w_curMask;
                            grantRank <= r_curRank;
                            r_holdCnt <= c_HOLD_W'(1);
                        end
                    end
                end
                S_SWITCH: begin
                    r_curRank <= r_nextRank;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (CMDTurnaroundFree) begin
                        // A rank that withdrew its request meanwhile is not granted.
                        if (w_elig[r_curRank]) begin
                            cmdGrant  <= w_curMask;
                            grantRank <= r_curRank;
                            r_holdCnt <= c_HOLD_W'(1);
                        end
                        r_state <= S_ACTIVE;
                    end
                end
                default: begin
                    r_state <= S_ACTIVE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_rank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_rank_arbiter
// Description : Scoreboard bench for cmd_rank_arbiter. Directed stimulus
//               pushes expected grant/transition events, each with its cycle,
//               into a queue. A negedge monitor pops an event and compares it
//               whenever the DUT shows a grant or a transition. A small
//               turnaround timer model (tRTRS=2) drives CMDTurnaroundFree.
//               The bench follows CMD_RANK_HOLD_EN in the same way as the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_rank_arbiter;

    localparam int NR    = 4;
    localparam int TRTRS = 2;

    typedef struct {
        bit isGrant;
        int rank;
        int at;
    } ev_t;

    logic          clk;
    logic          rst;
    logic [NR-1:0] rankReq;
    logic          free;
    logic [NR-1:0] cmdGrant;
    logic [1:0]    grantRank;
    logic          rankTransition;
    logic          holdOff;
    logic          freePrev;
    int            trCnt;
    int            cyc;
    int            nCompared;
    int            nMismatched;
    ev_t           expQ[$];

    cmd_rank_arbiter #(
        .NUM_RANK(NR),
        .MAX_HOLD(4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rankReq          (rankReq),
        .CMDTurnaroundFree(free),
        .cmdGrant         (cmdGrant),
        .grantRank        (grantRank),
        .rankTransition   (rankTransition)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Turnaround timer: bus busy in the transition cycle plus TRTRS-1 more.
    assign free = !holdOff && !rankTransition && (trCnt == 0);
    always @(posedge clk or negedge rst) begin
        if (!rst)                trCnt <= 0;
        else if (rankTransition) trCnt <= TRTRS - 1;
        else if (trCnt > 0)      trCnt <= trCnt - 1;
    end

    always @(posedge clk) freePrev <= free;

    // Monitor: every grant or transition must match the next expected event.
    always @(negedge clk) begin : monitor
        ev_t ev;
        bit  ok;
        if (rst === 1'b1 && (cmdGrant != '0 || rankTransition)) begin
            nCompared++;
            if (expQ.size() == 0) begin
                nMismatched++;
                $display("FAIL unexpected_event: cyc=%0d grant=%b trans=%b, required no activity",
                         cyc, cmdGrant, rankTransition);
            end else begin
                ev = expQ.pop_front();
                ok = (ev.at == cyc) && (rankTransition == !ev.isGrant);
                if (ev.isGrant)
                    ok = ok && (cmdGrant == (4'b0001 << ev.rank))
                            && (int'(grantRank) == ev.rank) && (freePrev == 1'b1);
                else
                    ok = ok && (cmdGrant == '0);
                if (!ok) begin
                    nMismatched++;
                    $display("FAIL event: cyc=%0d grant=%b grantRank=%0d trans=%b freePrev=%b, required %s rank %0d at cyc %0d",
                             cyc, cmdGrant, grantRank, rankTransition, freePrev,
                             ev.isGrant ? "grant" : "transition", ev.rank, ev.at);
                end
            end
        end
    end

    task automatic expG(input int r, input int at);
        expQ.push_back('{isGrant: 1'b1, rank: r, at: at});
    endtask

    task automatic expT(input int at);
        expQ.push_back('{isGrant: 1'b0, rank: 0, at: at});
    endtask

    task automatic toCyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic chkZero(input string name);
        nCompared++;
        if (cmdGrant !== '0 || rankTransition !== 1'b0 || grantRank !== '0) begin
            nMismatched++;
            $display("FAIL %s: grant=%b trans=%b grantRank=%0d, required all zero",
                     name, cmdGrant, rankTransition, grantRank);
        end
    endtask

    task automatic drain(input string name);
        repeat (12) @(negedge clk);
        nCompared++;
        if (expQ.size() != 0) begin
            nMismatched++;
            $display("FAIL %s: %0d expected events missing, next required at cyc %0d, now cyc %0d",
                     name, expQ.size(), expQ[0].at, cyc);
            expQ.delete();
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        #2 rst = 1'b0;
        rankReq = '0;
        holdOff = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        int s;
        nCompared   = 0;
        nMismatched = 0;
        rst         = 1'b0;
        rankReq     = '0;
        holdOff     = 1'b0;
        repeat (3) @(negedge clk);
        chkZero("reset_state");
        #2 rst = 1'b1;
        @(negedge clk);

        // Single requester: grant one cycle later, then one every 2 cycles.
        t = cyc;
        for (int i = 0; i < 6; i++) expG(2, t + 1 + 2 * i);
        rankReq = 4'b0100;
        toCyc(t + 11);
        rankReq = '0;
        drain("single_rank");

        // Two ranks contending, starting from rank 0.
        doReset();
        t = cyc;
`ifdef CMD_RANK_HOLD_EN
        for (int i = 0; i < 4; i++) expG(0, t + 1 + 2 * i);
        expT(t + 8);
        expG(1, t + 11);
        s = t + 11;
`else
        expG(0, t + 1);  expT(t + 2);
        expG(1, t + 5);  expT(t + 6);
        expG(0, t + 9);  expT(t + 10);
        expG(1, t + 13);
        s = t + 13;
`endif
        rankReq = 4'b0011;
        toCyc(s);
        rankReq = '0;
        drain("two_rank");

        // Start on rank 3, all request: rotation wraps to 0, then 1, 2, 3.
        doReset();
        t = cyc;
        expG(3, t + 1);
`ifdef CMD_RANK_HOLD_EN
        for (int i = 1; i < 4; i++) expG(3, t + 1 + 2 * i);
        for (int k = 0; k < 3; k++) begin
            expT(t + 8 + 10 * k);
            for (int i = 0; i < 4; i++) expG(k, t + 11 + 10 * k + 2 * i);
        end
        expT(t + 38);
        expG(3, t + 41);
        s = t + 41;
`else
        for (int k = 0; k < 4; k++) begin
            expT(t + 2 + 4 * k);
            expG(k, t + 5 + 4 * k);
        end
        s = t + 17;
`endif
        rankReq = 4'b1000;
        toCyc(t + 1);
        rankReq = 4'b1111;
        toCyc(s);
        rankReq = '0;
        drain("wrap_rotation");

        // Bus busy in ACTIVE: no grant until free returns.
        doReset();
        t = cyc;
        expG(0, t + 4);
        holdOff = 1'b1;
        rankReq = 4'b0001;
        toCyc(t + 3);
        holdOff = 1'b0;
        toCyc(t + 4);
        rankReq = '0;
        drain("busy_bus");

        // Target rank drops its request during WAIT.
        doReset();
        t = cyc;
        expG(1, t + 1);
        expT(t + 2);
        rankReq = 4'b0010;
        toCyc(t + 1);
        rankReq = 4'b0100;
        toCyc(t + 3);
        rankReq = '0;
        toCyc(t + 8);
        expG(2, t + 9);
        rankReq = 4'b0100;
        toCyc(t + 9);
        rankReq = '0;
        drain("drop_in_wait");

        // Asynchronous reset during SWITCH and during WAIT with a grant pending.
        doReset();
        t = cyc;
        expG(2, t + 1);
        expT(t + 2);
        rankReq = 4'b0100;
        toCyc(t + 1);
        rankReq = 4'b0010;
        toCyc(t + 2);
        #2 rst = 1'b0;
        #1 chkZero("reset_in_switch");
        expG(1, t + 7);
        toCyc(t + 6);
        #2 rst = 1'b1;
        s = t + 7;
        toCyc(s);
        expT(s + 1);
        rankReq = 4'b0001;
        toCyc(s + 3);
        #2 rst = 1'b0;
        #1 chkZero("reset_in_wait");
        expG(0, s + 6);
        toCyc(s + 5);
        #2 rst = 1'b1;
        toCyc(s + 6);
        rankReq = '0;
        drain("reset_recovery");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
